flip_mask_assembler: RTL and testbench
======================================

Name: flip_mask_assembler

Overview:
Rebuilds a spin-flip bitmask from a stream of binary spin indices. It does the reverse of the flip-filter priority arbiter, which turns a mask into indices. Indices arrive one per cycle over a valid/ready handshake and are OR-ed into a NUM_SPINS-wide mask. The completed mask is then presented downstream, also under valid/ready, to the spin-update stage.

Parameters:
- NUM_SPINS, 256, width of the mask, i.e. the number of spins addressable by an index.
- MAX_FLIPS, 16, maximum number of distinct bits per mask; reaching it closes the mask automatically.
- IDX_W, $clog2(NUM_SPINS), derived localparam, index width.
- CNT_W, $clog2(MAX_FLIPS+1), derived localparam, count width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- en_i  in  1  accept enable; gates only the index input side.
- flush_i  in  1  synchronous clear of the mask under construction and of any held output.
- idx_valid_i  in  1  index valid.
- idx_ready_o  out  1  index ready.
- idx_i  in  IDX_W  spin index.
- idx_last_i  in  1  marks the final index of the current mask.
- mask_valid_o  out  1  assembled mask valid.
- mask_ready_i  in  1  downstream ready.
- mask_o  out  NUM_SPINS  assembled flip mask.
- flip_cnt_o  out  CNT_W  number of distinct bits set in mask_o.
- dup_o  out  1  at least one duplicate index was received for this mask.
- err_o  out  1  at least one index >= NUM_SPINS was received for this mask.

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_ni is synchronous and active-low.
- Reset values: state COLLECT, mask 0, count 0, dup 0, err 0. Outputs after reset: mask_valid_o=0, idx_ready_o=en_i, mask_o=0, flip_cnt_o=0, dup_o=0, err_o=0.
- FSM states: COLLECT and HOLD.
- COLLECT, ready: idx_ready_o = en_i & ~flush_i. An accept is idx_valid_i & idx_ready_o.
- COLLECT, accept of an in-range index whose bit is clear: set the bit and count+1.
- COLLECT, accept of an in-range index whose bit is already set: dup=1, mask and count unchanged.
- COLLECT, accept with idx_i >= NUM_SPINS: err=1, index dropped. This case is only reachable when NUM_SPINS is not a power of 2.
- COLLECT, closing condition: an accept with idx_last_i=1, or an accept that brings count to MAX_FLIPS. When the mask closes, go to HOLD on the next edge.
- HOLD: mask_valid_o=1 and idx_ready_o=0, with no bypass. mask_o, flip_cnt_o, dup_o and err_o stay stable until mask_valid_o & mask_ready_i.
- HOLD, on the output handshake: clear mask, count and flags, and return to COLLECT. Ready may assert again in the following cycle.
- Latency: mask_valid_o rises one cycle after the closing accept. Minimum throughput is a 1-index mask every 2 cycles.
- en_i=0: no index is accepted and state is frozen. A mask already in HOLD can still hand off regardless of en_i.
- flush_i: clears to the reset state on the next edge. It wins over a simultaneous accept or output handshake; mask_valid_o is deasserted and the held mask is lost.
- Empty mask: a closing accept whose index is a duplicate or out of range still closes the mask. A mask may therefore be emitted with flip_cnt_o=0 and err_o=1.
- Count width: count saturates at MAX_FLIPS by construction and never wraps. Duplicates never increment it.
- Mask outputs: mask_o and flip_cnt_o come directly from registers, with no combinational path from idx_i.

Decomposition:
- Shared flip_filter_pkg:
  - state enum typedef fma_state_e {COLLECT, HOLD}.
  - function idx_width(n) = $clog2(n), reused by the arbiter and this block.
- One natural combinational sub-module: bin_to_onehot (IDX_W in, NUM_SPINS out, all zero when out of range). It is the inverse of onehot_to_bin and is used to form the set/duplicate-test vector.
- The FSM, counter and flags stay in the top module.

Test Plan:
- NUM_SPINS=256, MAX_FLIPS=16, mask_ready_i=1; indices 3, 200, 17, last on 17 -> one cycle later mask_valid_o=1, mask_o bits {3,17,200} set, flip_cnt_o=3, dup_o=0.
- Indices 5, 5, 9(last) -> mask bits {5,9}, flip_cnt_o=2, dup_o=1.
- Indices 0..15 without any last -> mask closes after index 15, flip_cnt_o=16. During HOLD, idx_ready_o=0 and index 20 is not accepted. After the handshake, index 20 starts a fresh mask.
- mask_ready_i held low for 5 cycles in HOLD -> mask_o, flip_cnt_o and mask_valid_o stable throughout. Handshake on cycle 6, and idx_ready_o=1 on cycle 7.
- flush_i during COLLECT after indices 1 and 2; then index 4 (last) -> emitted mask has only bit 4 set, flip_cnt_o=1. flush_i in HOLD -> mask_valid_o=0 on the next cycle.
- NUM_SPINS=200; index 250 (last) -> mask_o=0, flip_cnt_o=0, err_o=1. rst_ni low mid-collection -> next mask starts empty.

Source files
------------

// File: rtl/flip_filter_pkg.sv
// Shared types and helpers for the flip-filter arbiter and the mask assembler.
package flip_filter_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } fma_state_e;

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/flip_mask_assembler_bin_to_onehot.sv
// Binary index to one-hot decoder; an index with no matching spin yields all zeros.
module bin_to_onehot #(
  parameter int NUM_SPINS = 256,
  parameter int IDX_W     = 8
) (
  input  logic [IDX_W-1:0]     idx,
  output logic [NUM_SPINS-1:0] onehot
);

  for (genvar gi = 0; gi < NUM_SPINS; gi++) begin : g_dec
    assign onehot[gi] = (idx == IDX_W'(gi));
  end

endmodule

// File: rtl/flip_mask_assembler.sv
// Accumulates a stream of spin indices into a flip mask and hands the closed
// mask downstream under valid/ready.
module flip_mask_assembler
  import flip_filter_pkg::*;
#(
  parameter  int NUM_SPINS = 256,
  parameter  int MAX_FLIPS = 16,
  localparam int IDX_W     = idx_width(NUM_SPINS),
  localparam int CNT_W     = idx_width(MAX_FLIPS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 flush_i,
  input  logic                 idx_valid_i,
  output logic                 idx_ready_o,
  input  logic [IDX_W-1:0]     idx_i,
  input  logic                 idx_last_i,
  output logic                 mask_valid_o,
  input  logic                 mask_ready_i,
  output logic [NUM_SPINS-1:0] mask_o,
  output logic [CNT_W-1:0]     flip_cnt_o,
  output logic                 dup_o,
  output logic                 err_o
);

  fma_state_e           state_reg, state_next;
  logic [NUM_SPINS-1:0] mask_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 dup_reg, err_reg;

  logic [NUM_SPINS-1:0] onehot;
  logic                 accept, in_range, hit, new_bit, close, handoff;

  bin_to_onehot #(
    .NUM_SPINS (NUM_SPINS),
    .IDX_W     (IDX_W)
  ) u_dec (
    .idx    (idx_i),
    .onehot (onehot)
  );

  assign in_range = |onehot;
  assign hit      = |(onehot & mask_reg);
  assign accept   = idx_valid_i & idx_ready_o;
  assign new_bit  = accept & in_range & ~hit;
  // Only a fresh bit can reach the flip limit; duplicates and drops never count.
  assign close    = accept & (idx_last_i | (new_bit & (cnt_reg == CNT_W'(MAX_FLIPS - 1))));
  assign handoff  = mask_valid_o & mask_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_reg <= COLLECT;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (flush_i) begin
      state_next = COLLECT;
    end else begin
      case (state_reg)
        COLLECT: if (close)   state_next = HOLD;
        HOLD:    if (handoff) state_next = COLLECT;
        default: state_next = COLLECT;
      endcase
    end
  end

  always_comb begin
    mask_valid_o = (state_reg == HOLD);
    idx_ready_o  = (state_reg == COLLECT) & en_i & ~flush_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i || handoff) begin
      mask_reg <= '0;
      cnt_reg  <= '0;
      dup_reg  <= 1'b0;
      err_reg  <= 1'b0;
    end else if (accept) begin
      if (new_bit) begin
        mask_reg <= mask_reg | onehot;
        cnt_reg  <= cnt_reg + 1'b1;
      end else if (in_range) begin
        dup_reg <= 1'b1;
      end else begin
        err_reg <= 1'b1;
      end
    end
  end

  assign mask_o     = mask_reg;
  assign flip_cnt_o = cnt_reg;
  assign dup_o      = dup_reg;
  assign err_o      = err_reg;

endmodule

// File: tb/tb_flip_mask_assembler.sv
// Self-checking bench: directed scenarios plus randomized masks against a set-based model.
module tb_flip_mask_assembler;

  localparam int N  = 256;
  localparam int NS = 200;
  localparam int MF = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          idx_valid_i = 1'b0;
  logic          idx_last_i = 1'b0;
  logic          mask_ready_i = 1'b0;
  logic [7:0]    idx_i = '0;
  logic          idx_ready_o, mask_valid_o, dup_o, err_o;
  logic [N-1:0]  mask_o;
  logic [4:0]    flip_cnt_o;
  logic          r200, v200, d200, e200;
  logic [NS-1:0] m200;
  logic [4:0]    c200;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  flip_mask_assembler #(.NUM_SPINS(N), .MAX_FLIPS(MF)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .flush_i(flush_i),
    .idx_valid_i(idx_valid_i), .idx_ready_o(idx_ready_o), .idx_i(idx_i),
    .idx_last_i(idx_last_i), .mask_valid_o(mask_valid_o), .mask_ready_i(mask_ready_i),
    .mask_o(mask_o), .flip_cnt_o(flip_cnt_o), .dup_o(dup_o), .err_o(err_o)
  );

  flip_mask_assembler #(.NUM_SPINS(NS), .MAX_FLIPS(MF)) dut200 (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .flush_i(flush_i),
    .idx_valid_i(idx_valid_i), .idx_ready_o(r200), .idx_i(idx_i),
    .idx_last_i(idx_last_i), .mask_valid_o(v200), .mask_ready_i(mask_ready_i),
    .mask_o(m200), .flip_cnt_o(c200), .dup_o(d200), .err_o(e200)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Expected result of a mask: a set of spins, its size, and the two sticky flags.
  function automatic void ref_model(input int idxs[$], input bit lasts[$], input int n,
                                    output logic [N-1:0] m, output int c, output bit d,
                                    output bit e, output int used);
    m = '0; c = 0; d = 0; e = 0; used = 0;
    for (int i = 0; i < idxs.size(); i++) begin
      if (idxs[i] >= n) e = 1;
      else if (m[idxs[i]]) d = 1;
      else begin m[idxs[i]] = 1'b1; c++; end
      used = i + 1;
      if (lasts[i] || c == MF) break;
    end
  endfunction

  task automatic drive_seq(input int idxs[$], input bit lasts[$], input int used, input bit gaps);
    for (int i = 0; i < used; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          en_i = 1'b0; idx_valid_i = 1'b1; idx_last_i = 1'b1; idx_i = 8'($urandom_range(0, 255));
        end else begin
          idx_valid_i = 1'b0;
        end
        step();
        en_i = 1'b1;
      end
      idx_valid_i = 1'b1; idx_i = 8'(idxs[i]); idx_last_i = lasts[i];
      step();
    end
    idx_valid_i = 1'b0; idx_last_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; en_i = 1'b1;
    step(); step();
    rst_ni = 1'b1;
    checks++; if (mask_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", mask_valid_o); end
    checks++; if (idx_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", idx_ready_o); end
    checks++; if (mask_o !== '0) begin errors++; $display("FAIL reset_mask got %0h exp 0", mask_o); end
    checks++; if (flip_cnt_o !== 5'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", flip_cnt_o); end
    checks++; if (dup_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL reset_flags got %0b%0b exp 00", dup_o, err_o); end
    en_i = 1'b0; #1;
    checks++; if (idx_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_en0 got %0b exp 0", idx_ready_o); end
    en_i = 1'b1;
  endtask

  task automatic test_basic();
    int idxs[$] = '{3, 200, 17};
    bit lasts[$] = '{0, 0, 1};
    logic [N-1:0] m; int c, used; bit d, e;
    ref_model(idxs, lasts, N, m, c, d, e, used);
    mask_ready_i = 1'b1;
    drive_seq(idxs, lasts, used, 1'b0);
    $display("basic mask cnt %0d dup %0b err %0b", flip_cnt_o, dup_o, err_o);
    checks++; if (mask_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", mask_valid_o); end
    checks++; if (mask_o !== m) begin errors++; $display("FAIL basic_mask got %0h exp %0h", mask_o, m); end
    checks++; if (flip_cnt_o !== 5'd3 || dup_o !== 1'b0) begin errors++; $display("FAIL basic_cnt got %0d/%0b exp 3/0", flip_cnt_o, dup_o); end
    step();
    mask_ready_i = 1'b0;
    checks++; if (mask_valid_o !== 1'b0 || idx_ready_o !== 1'b1) begin errors++; $display("FAIL basic_handoff got %0b%0b exp 01", mask_valid_o, idx_ready_o); end
  endtask

  task automatic test_dup();
    int idxs[$] = '{5, 5, 9};
    bit lasts[$] = '{0, 0, 1};
    logic [N-1:0] m; int c, used; bit d, e;
    ref_model(idxs, lasts, N, m, c, d, e, used);
    drive_seq(idxs, lasts, used, 1'b0);
    $display("dup mask cnt %0d dup %0b err %0b", flip_cnt_o, dup_o, err_o);
    checks++; if (mask_o !== m) begin errors++; $display("FAIL dup_mask got %0h exp %0h", mask_o, m); end
    checks++; if (flip_cnt_o !== 5'd2) begin errors++; $display("FAIL dup_cnt got %0d exp 2", flip_cnt_o); end
    checks++; if (dup_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL dup_flags got %0b%0b exp 10", dup_o, err_o); end
    mask_ready_i = 1'b1; step(); mask_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] m20;
    for (int i = 0; i < 16; i++) begin
      idx_valid_i = 1'b1; idx_i = 8'(i); idx_last_i = 1'b0;
      step();
    end
    idx_i = 8'd20;
    $display("auto-close mask cnt %0d", flip_cnt_o);
    for (int k = 0; k < 5; k++) begin
      checks++; if (mask_valid_o !== 1'b1 || idx_ready_o !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got %0b%0b exp 10", k, mask_valid_o, idx_ready_o); end
      checks++; if (mask_o !== N'(32'hFFFF) || flip_cnt_o !== 5'd16) begin errors++; $display("FAIL bp_stable%0d got %0h/%0d exp ffff/16", k, mask_o, flip_cnt_o); end
      step();
    end
    mask_ready_i = 1'b1; idx_last_i = 1'b1;
    step();
    mask_ready_i = 1'b0;
    checks++; if (mask_valid_o !== 1'b0 || idx_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release got %0b%0b exp 01", mask_valid_o, idx_ready_o); end
    step();
    idx_valid_i = 1'b0; idx_last_i = 1'b0;
    m20 = '0; m20[20] = 1'b1;
    checks++; if (mask_valid_o !== 1'b1 || mask_o !== m20 || flip_cnt_o !== 5'd1) begin errors++; $display("FAIL bp_fresh got %0b/%0h/%0d exp 1/%0h/1", mask_valid_o, mask_o, flip_cnt_o, m20); end
    mask_ready_i = 1'b1; step(); mask_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    logic [N-1:0] m4;
    idx_valid_i = 1'b1; idx_last_i = 1'b0;
    idx_i = 8'd1; step();
    idx_i = 8'd2; step();
    flush_i = 1'b1; idx_i = 8'd7;
    #1;
    checks++; if (idx_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b exp 0", idx_ready_o); end
    step();
    flush_i = 1'b0; idx_i = 8'd4; idx_last_i = 1'b1;
    step();
    idx_valid_i = 1'b0; idx_last_i = 1'b0;
    m4 = '0; m4[4] = 1'b1;
    checks++; if (mask_o !== m4 || flip_cnt_o !== 5'd1) begin errors++; $display("FAIL flush_mask got %0h/%0d exp %0h/1", mask_o, flip_cnt_o, m4); end
    flush_i = 1'b1; mask_ready_i = 1'b1;
    step();
    flush_i = 1'b0; mask_ready_i = 1'b0;
    checks++; if (mask_valid_o !== 1'b0 || mask_o !== '0) begin errors++; $display("FAIL flush_hold got %0b/%0h exp 0/0", mask_valid_o, mask_o); end
  endtask

  task automatic test_enable();
    en_i = 1'b0; idx_valid_i = 1'b1; idx_i = 8'd33; idx_last_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (idx_ready_o !== 1'b0 || mask_valid_o !== 1'b0 || flip_cnt_o !== 5'd0) begin errors++; $display("FAIL en_frozen%0d got %0b%0b/%0d exp 00/0", k, idx_ready_o, mask_valid_o, flip_cnt_o); end
    end
    en_i = 1'b1;
    step();
    idx_valid_i = 1'b0; idx_last_i = 1'b0;
    checks++; if (mask_valid_o !== 1'b1 || mask_o[33] !== 1'b1 || flip_cnt_o !== 5'd1) begin errors++; $display("FAIL en_accept got %0b/%0b/%0d exp 1/1/1", mask_valid_o, mask_o[33], flip_cnt_o); end
    en_i = 1'b0; mask_ready_i = 1'b1;
    step();
    mask_ready_i = 1'b0;
    checks++; if (mask_valid_o !== 1'b0) begin errors++; $display("FAIL en_handoff got %0b exp 0", mask_valid_o); end
    en_i = 1'b1;
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      int idxs[$]; bit lasts[$];
      logic [N-1:0] m; int c, used, len, hi, stall; bit d, e;
      len = $urandom_range(1, 24);
      hi  = ($urandom_range(0, 1) == 1) ? 31 : 255;
      for (int i = 0; i < len; i++) begin
        idxs.push_back($urandom_range(0, hi));
        lasts.push_back((i == len - 1) || ($urandom_range(0, 9) == 0));
      end
      ref_model(idxs, lasts, N, m, c, d, e, used);
      drive_seq(idxs, lasts, used, 1'b1);
      $display("rand %0d: %0d indices cnt %0d dup %0b", t, used, flip_cnt_o, dup_o);
      checks++; if (mask_valid_o !== 1'b1) begin errors++; $display("FAIL rand%0d_valid got %0b exp 1", t, mask_valid_o); end
      checks++; if (mask_o !== m) begin errors++; $display("FAIL rand%0d_mask got %0h exp %0h", t, mask_o, m); end
      checks++; if (flip_cnt_o !== 5'(c) || dup_o !== d || err_o !== e) begin errors++; $display("FAIL rand%0d_cnt got %0d/%0b%0b exp %0d/%0b%0b", t, flip_cnt_o, dup_o, err_o, c, d, e); end
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        step();
        checks++; if (mask_valid_o !== 1'b1 || mask_o !== m) begin errors++; $display("FAIL rand%0d_stall got %0b/%0h exp 1/%0h", t, mask_valid_o, mask_o, m); end
      end
      mask_ready_i = 1'b1; step(); mask_ready_i = 1'b0;
      checks++; if (mask_valid_o !== 1'b0 || idx_ready_o !== 1'b1) begin errors++; $display("FAIL rand%0d_release got %0b%0b exp 01", t, mask_valid_o, idx_ready_o); end
    end
  endtask

  task automatic test_non_pow2();
    logic [NS-1:0] m12;
    rst_ni = 1'b0; step(); rst_ni = 1'b1;
    idx_valid_i = 1'b1; idx_i = 8'd250; idx_last_i = 1'b1;
    step();
    idx_valid_i = 1'b0; idx_last_i = 1'b0;
    $display("np2 mask cnt %0d err %0b", c200, e200);
    checks++; if (v200 !== 1'b1 || m200 !== '0 || c200 !== 5'd0) begin errors++; $display("FAIL np2_empty got %0b/%0h/%0d exp 1/0/0", v200, m200, c200); end
    checks++; if (e200 !== 1'b1 || d200 !== 1'b0) begin errors++; $display("FAIL np2_err got %0b%0b exp 10", e200, d200); end
    mask_ready_i = 1'b1; step(); mask_ready_i = 1'b0;
    checks++; if (v200 !== 1'b0 || r200 !== 1'b1) begin errors++; $display("FAIL np2_release got %0b%0b exp 01", v200, r200); end
    idx_valid_i = 1'b1;
    idx_i = 8'd10; step();
    idx_i = 8'd11; step();
    idx_valid_i = 1'b0; rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    checks++; if (c200 !== 5'd0 || m200 !== '0) begin errors++; $display("FAIL np2_reset got %0d/%0h exp 0/0", c200, m200); end
    idx_valid_i = 1'b1; idx_i = 8'd12; idx_last_i = 1'b1;
    step();
    idx_valid_i = 1'b0; idx_last_i = 1'b0;
    m12 = '0; m12[12] = 1'b1;
    checks++; if (m200 !== m12 || c200 !== 5'd1 || e200 !== 1'b0) begin errors++; $display("FAIL np2_fresh got %0h/%0d/%0b exp %0h/1/0", m200, c200, e200, m12); end
    mask_ready_i = 1'b1; step(); mask_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dup();
    test_backpressure();
    test_flush();
    test_enable();
    test_random();
    test_non_pow2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
